// File: rtl/trace_capture_unit.sv
// Retirement trace monitor: samples commit signals while RUN, stores event
// records in a circular buffer and exposes them through a pop-style read port.
module trace_capture_unit #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100000,
  parameter int WRAP    = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               arm,
  input  logic                               clear,
  input  logic [DATA_W-1:0]                  pc,
  input  logic                               reg_we,
  input  logic [REG_AW-1:0]                  reg_addr,
  input  logic [DATA_W-1:0]                  reg_data,
  input  logic                               mem_re,
  input  logic                               mem_we,
  input  logic [DATA_W-1:0]                  mem_addr,
  input  logic [DATA_W-1:0]                  mem_wdata,
  input  logic [DATA_W-1:0]                  mem_rdata,
  input  logic                               halt,
  input  logic                               rd_en,
  output logic                               rd_valid,
  output logic [4+REG_AW+4*DATA_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]             count,
  output logic                               empty,
  output logic                               full,
  output logic                               overflow,
  output logic [CNT_W-1:0]                   cycle_count,
  output logic [CNT_W-1:0]                   inst_count,
  output logic [1:0]                         state
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 4 + REG_AW + 4 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    HALTED   = 2'b10,
    TIMEDOUT = 2'b11
  } state_t;

  state_t stateQ, stateD;

  logic [REC_W-1:0] buffer [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [DATA_W-1:0] memData;
  logic [REC_W-1:0] record;
  logic running, eventCyc, timeoutHit, capture, doPop, isFull, doWrite, lostSlot;

  assign running    = (stateQ == RUN);
  assign eventCyc   = running & (reg_we | mem_re | mem_we | halt);
  assign timeoutHit = running && (TIMEOUT != 0) && (cycle_count == TIMEOUT_LAST);
  // A halt on the timeout edge still wins, so its record is kept.
  assign capture    = eventCyc & (halt | ~timeoutHit);
  assign doPop      = rd_en & (count != '0);
  assign isFull     = (count == (AW+1)'(DEPTH));
  assign doWrite    = capture & (~isFull | doPop | (WRAP != 0));
  assign lostSlot   = capture & isFull & ~doPop;

  assign memData = mem_re ? mem_rdata : (mem_we ? mem_wdata : '0);
  assign record  = {halt, mem_we, mem_re, reg_we, pc, reg_addr, reg_data, mem_addr, memData};

  assign empty = (count == '0);
  assign full  = isFull;
  assign state = stateQ;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) stateQ <= IDLE;
    else                 stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (arm) stateD = RUN;
      RUN: begin
        if (halt)            stateD = HALTED;
        else if (timeoutHit) stateD = TIMEDOUT;
      end
      default: stateD = stateQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (doWrite) buffer[wrPtr] <= record;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= doPop;
      if (doPop) begin
        rd_data <= buffer[rdPtr];
        rdPtr   <= rdPtr + AW'(1);
      end
      if (doWrite) wrPtr <= wrPtr + AW'(1);
      // Overwriting in wrap mode retires the oldest entry, so the read side advances too.
      if (lostSlot) begin
        overflow <= 1'b1;
        if (WRAP != 0) rdPtr <= rdPtr + AW'(1);
      end
      if (doWrite && !doPop && !isFull) count <= count + (AW+1)'(1);
      else if (doPop && !doWrite)       count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cycle_count <= '0;
      inst_count  <= '0;
    end else if (running) begin
      if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_W'(1);
      if ((reg_we | mem_we | halt) && inst_count != CNT_MAX)
        inst_count <= inst_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_trace_capture_unit.sv
// Directed bench for trace_capture_unit: a vector table on a stop-mode unit plus
// hand sequences for wrap, timeout, saturation and simultaneous write/pop.
module tb_trace_capture_unit;

  localparam int RW = 72;

  logic clk = 1'b0;
  logic rst_n;
  logic arm, clear, reg_we, mem_re, mem_we, halt, rd_en;
  logic [15:0] pc, reg_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  reg_addr;

  // 0: stop mode, 1: wrap mode, 2: TIMEOUT=10, 3: 4-bit counters
  logic          rdValid [4];
  logic [RW-1:0] rdData  [4];
  logic [2:0]    cnt     [4];
  logic          emp     [4];
  logic          ful     [4];
  logic          ovf     [4];
  logic [1:0]    st      [4];
  logic [31:0]   cyc     [3];
  logic [31:0]   inst    [3];
  logic [3:0]    cycC, instC;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trace_capture_unit #(.DEPTH(4), .TIMEOUT(0), .WRAP(0)) dutS (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .pc(pc), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_data(reg_data), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .rd_en(rd_en), .rd_valid(rdValid[0]), .rd_data(rdData[0]), .count(cnt[0]),
    .empty(emp[0]), .full(ful[0]), .overflow(ovf[0]), .cycle_count(cyc[0]),
    .inst_count(inst[0]), .state(st[0]));

  trace_capture_unit #(.DEPTH(4), .TIMEOUT(0), .WRAP(1)) dutW (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .pc(pc), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_data(reg_data), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .rd_en(rd_en), .rd_valid(rdValid[1]), .rd_data(rdData[1]), .count(cnt[1]),
    .empty(emp[1]), .full(ful[1]), .overflow(ovf[1]), .cycle_count(cyc[1]),
    .inst_count(inst[1]), .state(st[1]));

  trace_capture_unit #(.DEPTH(4), .TIMEOUT(10), .WRAP(0)) dutT (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .pc(pc), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_data(reg_data), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .rd_en(rd_en), .rd_valid(rdValid[2]), .rd_data(rdData[2]), .count(cnt[2]),
    .empty(emp[2]), .full(ful[2]), .overflow(ovf[2]), .cycle_count(cyc[2]),
    .inst_count(inst[2]), .state(st[2]));

  trace_capture_unit #(.DEPTH(4), .TIMEOUT(0), .WRAP(0), .CNT_W(4)) dutC (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .pc(pc), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_data(reg_data), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .rd_en(rd_en), .rd_valid(rdValid[3]), .rd_data(rdData[3]), .count(cnt[3]),
    .empty(emp[3]), .full(ful[3]), .overflow(ovf[3]), .cycle_count(cycC),
    .inst_count(instC), .state(st[3]));

  typedef struct {
    logic        arm, clr, hlt, rwe;
    logic [3:0]  ra;
    logic [15:0] rdat, pcv;
    logic        mre, mwe;
    logic [15:0] ma, mwd, mrd;
    logic        pop;
    logic [1:0]  eSt;
    logic [2:0]  eCnt;
    logic [31:0] eInst;
    logic        eVal;
    logic [RW-1:0] eData;
  } vec_t;

  vec_t vecs [19];

  function automatic logic [RW-1:0] mkRec(logic [3:0] f, logic [15:0] p, logic [3:0] ra,
                                          logic [15:0] rdat, logic [15:0] ma, logic [15:0] md);
    return {f, p, ra, rdat, ma, md};
  endfunction

  function automatic vec_t mkVec(logic a, logic c, logic h, logic rwe, logic [3:0] ra,
                                 logic [15:0] rdat, logic [15:0] pcv, logic mre, logic mwe,
                                 logic [15:0] ma, logic [15:0] mwd, logic [15:0] mrd, logic pop,
                                 logic [1:0] eSt, logic [2:0] eCnt, logic [31:0] eInst,
                                 logic eVal, logic [RW-1:0] eData);
    vec_t v;
    v.arm = a; v.clr = c; v.hlt = h; v.rwe = rwe; v.ra = ra; v.rdat = rdat; v.pcv = pcv;
    v.mre = mre; v.mwe = mwe; v.ma = ma; v.mwd = mwd; v.mrd = mrd; v.pop = pop;
    v.eSt = eSt; v.eCnt = eCnt; v.eInst = eInst; v.eVal = eVal; v.eData = eData;
    return v;
  endfunction

  task automatic chk(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    arm = 0; clear = 0; halt = 0; reg_we = 0; mem_re = 0; mem_we = 0; rd_en = 0;
    pc = '0; reg_addr = '0; reg_data = '0; mem_addr = '0; mem_wdata = '0; mem_rdata = '0;
  endtask

  task automatic regWrite(logic [15:0] d);
    idleIn();
    reg_we = 1; reg_addr = 4'd1; reg_data = d; pc = d << 1;
  endtask

  task automatic clearArm();
    idleIn(); clear = 1; tick();
    idleIn(); arm = 1;   tick();
    idleIn();
  endtask

  task automatic chkReset(int u, string tag);
    chk({tag, " state"}, RW'(st[u]), '0);
    chk({tag, " count"}, RW'(cnt[u]), '0);
    chk({tag, " empty"}, RW'(emp[u]), RW'(1));
    chk({tag, " full"}, RW'(ful[u]), '0);
    chk({tag, " overflow"}, RW'(ovf[u]), '0);
    chk({tag, " rd_valid"}, RW'(rdValid[u]), '0);
    chk({tag, " rd_data"}, rdData[u], '0);
    if (u < 3) begin
      chk({tag, " cycle_count"}, RW'(cyc[u]), '0);
      chk({tag, " inst_count"}, RW'(inst[u]), '0);
    end
  endtask

  initial begin
    vecs[0]  = mkVec(0,0,0,0, 0,16'h0,16'h0, 0,0,16'h0,16'h0,16'h0, 0, 2'd0,3'd0,0,0,'0);
    vecs[1]  = mkVec(1,0,0,0, 0,16'h0,16'h0, 0,0,16'h0,16'h0,16'h0, 0, 2'd1,3'd0,0,0,'0);
    vecs[2]  = mkVec(0,0,0,1, 3,16'h00A5,16'h4, 0,0,16'h0,16'h0,16'h0, 0, 2'd1,3'd1,1,0,'0);
    vecs[3]  = mkVec(0,0,1,0, 0,16'h0,16'h6, 0,0,16'h0,16'h0,16'h0, 0, 2'd2,3'd2,2,0,'0);
    vecs[4]  = mkVec(0,0,0,0, 0,16'h0,16'h0, 0,0,16'h0,16'h0,16'h0, 1, 2'd2,3'd1,2,1,
                     mkRec(4'b0001,16'h4,4'd3,16'h00A5,16'h0,16'h0));
    vecs[5]  = mkVec(0,0,0,0, 0,16'h0,16'h0, 0,0,16'h0,16'h0,16'h0, 1, 2'd2,3'd0,2,1,
                     mkRec(4'b1000,16'h6,4'd0,16'h0,16'h0,16'h0));
    vecs[6]  = mkVec(0,0,0,0, 0,16'h0,16'h0, 0,0,16'h0,16'h0,16'h0, 1, 2'd2,3'd0,2,0,
                     mkRec(4'b1000,16'h6,4'd0,16'h0,16'h0,16'h0));
    vecs[7]  = mkVec(1,0,0,0, 0,16'h0,16'h0, 0,0,16'h0,16'h0,16'h0, 0, 2'd2,3'd0,2,0,
                     mkRec(4'b1000,16'h6,4'd0,16'h0,16'h0,16'h0));
    vecs[8]  = mkVec(1,1,0,1, 2,16'h0055,16'h8, 0,0,16'h0,16'h0,16'h0, 1, 2'd0,3'd0,0,0,'0);
    vecs[9]  = mkVec(1,0,0,0, 0,16'h0,16'h0, 0,0,16'h0,16'h0,16'h0, 0, 2'd1,3'd0,0,0,'0);
    vecs[10] = mkVec(0,0,0,0, 0,16'h0,16'h20, 1,0,16'h10,16'h5555,16'h1234, 0, 2'd1,3'd1,0,0,'0);
    vecs[11] = mkVec(0,0,0,0, 0,16'h0,16'h22, 0,1,16'h12,16'hBEEF,16'h7777, 0, 2'd1,3'd2,1,0,'0);
    vecs[12] = mkVec(0,0,0,0, 0,16'h0,16'h0, 0,0,16'h0,16'h0,16'h0, 1, 2'd1,3'd1,1,1,
                     mkRec(4'b0010,16'h20,4'd0,16'h0,16'h10,16'h1234));
    vecs[13] = mkVec(0,0,0,0, 0,16'h0,16'h0, 0,0,16'h0,16'h0,16'h0, 1, 2'd1,3'd0,1,1,
                     mkRec(4'b0100,16'h22,4'd0,16'h0,16'h12,16'hBEEF));
    vecs[14] = mkVec(0,0,0,0, 0,16'h0,16'h0, 0,0,16'h0,16'h0,16'h0, 0, 2'd1,3'd0,1,0,
                     mkRec(4'b0100,16'h22,4'd0,16'h0,16'h12,16'hBEEF));
    vecs[15] = mkVec(0,0,0,1, 5,16'h0ABC,16'h24, 1,1,16'h30,16'h2222,16'h1111, 0, 2'd1,3'd1,2,0,
                     mkRec(4'b0100,16'h22,4'd0,16'h0,16'h12,16'hBEEF));
    vecs[16] = mkVec(0,0,0,0, 0,16'h0,16'h0, 0,0,16'h0,16'h0,16'h0, 1, 2'd1,3'd0,2,1,
                     mkRec(4'b0111,16'h24,4'd5,16'h0ABC,16'h30,16'h1111));
    vecs[17] = mkVec(0,0,0,1, 7,16'h0077,16'h26, 0,0,16'h0,16'h0,16'h0, 1, 2'd1,3'd1,3,0,
                     mkRec(4'b0111,16'h24,4'd5,16'h0ABC,16'h30,16'h1111));
    vecs[18] = mkVec(0,0,0,0, 0,16'h0,16'h0, 0,0,16'h0,16'h0,16'h0, 1, 2'd1,3'd0,3,1,
                     mkRec(4'b0001,16'h26,4'd7,16'h0077,16'h0,16'h0));

    idleIn();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    chkReset(0, "reset S");
    chkReset(2, "reset T");

    for (int i = 0; i < 19; i++) begin
      arm = vecs[i].arm; clear = vecs[i].clr; halt = vecs[i].hlt; reg_we = vecs[i].rwe;
      reg_addr = vecs[i].ra; reg_data = vecs[i].rdat; pc = vecs[i].pcv;
      mem_re = vecs[i].mre; mem_we = vecs[i].mwe; mem_addr = vecs[i].ma;
      mem_wdata = vecs[i].mwd; mem_rdata = vecs[i].mrd; rd_en = vecs[i].pop;
      tick();
      chk($sformatf("v%0d state", i), RW'(st[0]), RW'(vecs[i].eSt));
      chk($sformatf("v%0d count", i), RW'(cnt[0]), RW'(vecs[i].eCnt));
      chk($sformatf("v%0d empty", i), RW'(emp[0]), RW'(vecs[i].eCnt == 0));
      chk($sformatf("v%0d inst_count", i), RW'(inst[0]), RW'(vecs[i].eInst));
      chk($sformatf("v%0d rd_valid", i), RW'(rdValid[0]), RW'(vecs[i].eVal));
      chk($sformatf("v%0d rd_data", i), rdData[0], vecs[i].eData);
    end

    // Six writes into four slots: stop mode keeps 1..4, wrap mode keeps 3..6.
    clearArm();
    for (int i = 1; i <= 6; i++) begin
      regWrite(16'(i)); tick();
    end
    idleIn(); tick();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("wrap%0d count", u), RW'(cnt[u]), RW'(4));
      chk($sformatf("wrap%0d full", u), RW'(ful[u]), RW'(1));
      chk($sformatf("wrap%0d overflow", u), RW'(ovf[u]), RW'(1));
    end
    for (int j = 1; j <= 5; j++) begin
      idleIn(); rd_en = 1; tick();
      if (j <= 4) begin
        chk($sformatf("stop pop%0d valid", j), RW'(rdValid[0]), RW'(1));
        chk($sformatf("stop pop%0d data", j), RW'(rdData[0][32 +: 16]), RW'(j));
        chk($sformatf("wrap pop%0d valid", j), RW'(rdValid[1]), RW'(1));
        chk($sformatf("wrap pop%0d data", j), RW'(rdData[1][32 +: 16]), RW'(j + 2));
      end else begin
        chk("stop pop5 valid", RW'(rdValid[0]), '0);
        chk("stop pop5 empty", RW'(emp[0]), RW'(1));
        chk("wrap pop5 valid", RW'(rdValid[1]), '0);
        chk("wrap pop5 data hold", RW'(rdData[1][32 +: 16]), RW'(6));
      end
    end

    // Watchdog after exactly ten RUN cycles; other units keep counting.
    clearArm();
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 9) begin
        chk("timeout k9 state", RW'(st[2]), RW'(1));
        chk("timeout k9 cycles", RW'(cyc[2]), RW'(9));
      end
    end
    chk("timeout state", RW'(st[2]), RW'(3));
    chk("timeout cycles", RW'(cyc[2]), RW'(10));
    for (int k = 1; k <= 8; k++) begin
      regWrite(16'(k)); tick();
    end
    idleIn();
    chk("timeout frozen cycles", RW'(cyc[2]), RW'(10));
    chk("timeout no capture", RW'(cnt[2]), '0);
    chk("timeout no inst", RW'(inst[2]), '0);
    chk("timeout stays", RW'(st[2]), RW'(3));
    chk("nodog state", RW'(st[0]), RW'(1));
    chk("nodog cycles", RW'(cyc[0]), RW'(18));
    chk("nodog inst", RW'(inst[0]), RW'(8));
    chk("sat cycles", RW'(cycC), RW'(15));
    chk("sat inst", RW'(instC), RW'(8));

    // Halt on the same edge the watchdog would fire: HALTED wins, record kept.
    clearArm();
    for (int k = 1; k <= 9; k++) tick();
    idleIn(); halt = 1; pc = 16'h0040; tick();
    idleIn();
    chk("halt+timeout state", RW'(st[2]), RW'(2));
    chk("halt+timeout count", RW'(cnt[2]), RW'(1));
    chk("halt+timeout cycles", RW'(cyc[2]), RW'(10));

    // Full buffer with a write and a pop on the same edge.
    clearArm();
    for (int i = 11; i <= 14; i++) begin
      regWrite(16'(i)); tick();
    end
    regWrite(16'd15); rd_en = 1; tick();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("fullpop%0d count", u), RW'(cnt[u]), RW'(4));
      chk($sformatf("fullpop%0d overflow", u), RW'(ovf[u]), '0);
      chk($sformatf("fullpop%0d data", u), RW'(rdData[u][32 +: 16]), RW'(11));
    end
    idleIn(); rd_en = 1; tick();
    chk("fullpop next S", RW'(rdData[0][32 +: 16]), RW'(12));
    chk("fullpop next W", RW'(rdData[1][32 +: 16]), RW'(12));

    // Clear mid-RUN, asserted alongside other activity.
    regWrite(16'd99); arm = 1; rd_en = 1; clear = 1; tick();
    idleIn();
    chkReset(0, "clear S");
    chkReset(1, "clear W");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
